start_screen_index_gen: RTL and testbench
=========================================

# start_screen_index_gen

Pixel-index stage upstream of the start-screen palette lookup. Converts VGA draw coordinates into a read address for the 320x240 start-screen index ROM and realigns the returned 4-bit index with the video timing. Applies a frame-driven reveal, a blinking "PRESS START" band and an exit sequence before passing the index to the palette stage. Also reports to the game FSM when the player has left the start screen.

## Interface
- IMG_W, 320: image width in ROM pixels; displayed at 2x scale.
- IMG_H, 240: image height in ROM pixels.
- ROM_LAT, 1: ROM read latency in cycles; legal values 1..2.
- REVEAL_STEP, 4: image rows revealed per frame during fade-in.
- BLINK_Y0, 176 / BLINK_Y1, 199: inclusive image-row band that blinks.
- Clk  in  1  system/pixel clock; every register advances every cycle.
- Reset  in  1  asynchronous, active-high.
- DrawX  in  10  current pixel column, 0..639.
- DrawY  in  10  current pixel row, 0..479.
- de  in  1  active-video qualifier for DrawX/DrawY.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- start_btn  in  1  raw, asynchronous start button.
- rom_addr  out  17  registered ROM address, (DrawY>>1)*IMG_W + (DrawX>>1).
- rom_q  in  4  ROM data, valid ROM_LAT cycles after rom_addr.
- index  out  4  palette index to the palette stage.
- index_valid  out  1  index corresponds to an active pixel.
- screen_done  out  1  one-cycle pulse when the exit sequence completes.

## Operation
- States: FADE_IN, SHOW, EXIT, DONE. Reset enters FADE_IN.
- FADE_IN: reveal_row (8-bit) starts at 0 and adds REVEAL_STEP on each frame_start, saturating at IMG_H. A pixel whose image row (DrawY>>1) is >= reveal_row is forced to index 0. At saturation, the next cycle enters SHOW.
- SHOW: frame_cnt (6-bit) is cleared on entry and increments on each frame_start, wrapping at 63. blink_on = ~frame_cnt[4], giving a 32-frame period. Pixels in rows BLINK_Y0..BLINK_Y1 are forced to 0 while blink_on=0.
- EXIT: all pixels are forced to 0. After the second frame_start in EXIT, screen_done pulses for 1 cycle and the block enters DONE.
- DONE: all pixels are forced to 0. The block stays in DONE until Reset.
- start_btn passes through a 2-flop synchronizer and a rising-edge detector; btn_rise is 1 cycle wide.
  - btn_rise in FADE_IN sets reveal_row=IMG_H and enters SHOW.
  - btn_rise in SHOW enters EXIT.
  - btn_rise is ignored in EXIT and DONE.
- btn_rise and frame_start in the same cycle: the button transition wins, and no counter increment is applied that cycle.
- Address arithmetic: (DrawY>>1) is 9 bits, multiplied by the constant IMG_W, plus (DrawX>>1) zero-extended. The result is 17 bits with no overflow for in-range coordinates.
- When de=0, rom_addr holds its last value. The mask flag is still pipelined with de, so index_valid=0 and index=0 for those pixels.

## Timing
- Stage 0 registers rom_addr, de and the force-zero flag. The flag is computed from the state, reveal_row and blink_on as they are in that cycle.
- Stages 1..ROM_LAT delay de and the flag to match rom_q.
- The output stage registers index = flag ? 0 : rom_q, and index_valid = delayed de.
- Latency from a DrawX/DrawY/de sample to index/index_valid is ROM_LAT+2 cycles. A state change mid-line therefore affects only pixels sampled after the change; no pixel mixes old and new masking.
- Reset values:
  - outputs: rom_addr=0, index=0, index_valid=0, screen_done=0.
  - internal: reveal_row=0, frame_cnt=0, synchronizer flops=0, all pipeline flags=0.
- Reset mid-frame clears the pipeline immediately. The first valid output appears ROM_LAT+2 cycles after Reset deasserts with de=1.

## Structure
- Package start_screen_pkg holds:
  - typedef enum logic [1:0] {FADE_IN, SHOW, EXIT, DONE} ss_state_t
  - localparams for the default IMG_W, IMG_H and ROM address width.
- Sub-module btn_sync_edge: 2-flop synchronizer plus rising-edge pulse, with async active-high reset. It is reusable for other buttons.
- The top level holds the state FSM, the counters and the ROM_LAT-deep shift pipeline for de/flag.

## Test plan
- Reset held with de=1, DrawX=100, DrawY=50 → index=0, index_valid=0, rom_addr=0. After release with ROM_LAT=1, 3 cycles later index_valid=1 and rom_addr=25*320+50=8050.
- FADE_IN after 10 frame_starts (reveal_row=40): pixel at DrawY=78 shows rom_q; pixel at DrawY=80 shows 0. After 60 frame_starts, state=SHOW.
- SHOW, rom_q=4'hA for all addresses: DrawY=360 (image row 180) outputs 0xA for frames 0..15 and 0 for frames 16..31. DrawY=100 outputs 0xA always.
- start_btn rising in FADE_IN at reveal_row=8 → next frame shows full image. A second press → EXIT, all-zero output, screen_done pulses exactly once, 1 cycle after the 2nd frame_start.
- btn_rise coincident with frame_start in SHOW at frame_cnt=5 → EXIT entered and frame_cnt stays 5. A button held high produces no second transition.
- Reset asserted mid-line during EXIT → state=FADE_IN, outputs 0 on the same cycle (asynchronous), no screen_done pulse.

Source files
------------

// File: rtl/start_screen_pkg.sv
// Shared types and default geometry for the start-screen index stage.
package start_screen_pkg;

  typedef enum logic [1:0] {FADE_IN, SHOW, EXIT, DONE} ss_state_t;

  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;
  localparam int ROM_AW    = 17;
  localparam int COORD_W   = 10;

endpackage

// File: rtl/start_screen_index_gen_if.sv
// Video-timing, ROM and game-FSM signals of the start-screen index stage.
interface start_screen_index_gen_if;
  import start_screen_pkg::*;

  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic               de;
  logic               frame_start;
  logic               start_btn;
  logic [ROM_AW-1:0]  rom_addr;
  logic [3:0]         rom_q;
  logic [3:0]         index;
  logic               index_valid;
  logic               screen_done;

  modport master (
    output DrawX, DrawY, de, frame_start, start_btn, rom_q,
    input  rom_addr, index, index_valid, screen_done
  );

  modport slave (
    input  DrawX, DrawY, de, frame_start, start_btn, rom_q,
    output rom_addr, index, index_valid, screen_done
  );

endinterface

// File: rtl/start_screen_index_gen_btn_sync_edge.sv
// Two-flop synchronizer with a one-cycle rising-edge pulse; reusable for any raw button.
module btn_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/start_screen_index_gen.sv
// Start-screen ROM addressing, reveal/blink/exit masking and ROM-latency realignment.
// state   | meaning
// FADE_IN | rows at or below reveal_row forced to 0; reveal_row grows per frame
// SHOW    | full image, PRESS START band blinks on frame_cnt[4]
// EXIT    | all pixels 0; second frame_start pulses screen_done
// DONE    | all pixels 0 until reset
module start_screen_index_gen
  import start_screen_pkg::*;
#(
  parameter int IMG_W       = IMG_W_DEF,
  parameter int IMG_H       = IMG_H_DEF,
  parameter int ROM_LAT     = 1,
  parameter int REVEAL_STEP = 4,
  parameter int BLINK_Y0    = 176,
  parameter int BLINK_Y1    = 199
) (
  input logic                     Clk,
  input logic                     Reset,
  start_screen_index_gen_if.slave bus
);

  localparam logic [7:0] REVEAL_MAX = 8'(IMG_H);

  ss_state_t         r_state;
  ss_state_t         w_state_nxt;
  logic [7:0]        r_reveal_row;
  logic [7:0]        w_reveal_nxt;
  logic [8:0]        w_reveal_sum;
  logic [5:0]        r_frame_cnt;
  logic [5:0]        w_frame_cnt_nxt;
  logic              r_exit_cnt;
  logic              w_exit_cnt_nxt;
  logic              r_screen_done;
  logic              w_done_nxt;
  logic              w_btn_rise;

  logic [8:0]        w_row;
  logic [8:0]        w_col;
  logic [ROM_AW-1:0] w_addr;
  logic              w_in_band;
  logic              w_blink_on;
  logic              w_flag;
  logic              w_unused;

  logic [ROM_AW-1:0]  r_rom_addr;
  logic               r_de0;
  logic               r_flag0;
  logic [ROM_LAT-1:0] r_de_pipe;
  logic [ROM_LAT-1:0] r_flag_pipe;
  logic [3:0]         r_index;
  logic               r_index_valid;

  btn_sync_edge u_btn (
    .i_clk  (Clk),
    .i_rst  (Reset),
    .i_btn  (bus.start_btn),
    .o_rise (w_btn_rise)
  );

  assign w_reveal_sum = {1'b0, r_reveal_row} + 9'(REVEAL_STEP);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= FADE_IN;
      r_reveal_row  <= '0;
      r_frame_cnt   <= '0;
      r_exit_cnt    <= 1'b0;
      r_screen_done <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_reveal_row  <= w_reveal_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_exit_cnt    <= w_exit_cnt_nxt;
      r_screen_done <= w_done_nxt;
    end
  end

  // A button edge takes priority over a coincident frame_start: no count that cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_reveal_nxt    = r_reveal_row;
    w_frame_cnt_nxt = r_frame_cnt;
    w_exit_cnt_nxt  = r_exit_cnt;
    w_done_nxt      = 1'b0;
    case (r_state)
      FADE_IN: begin
        if (w_btn_rise) begin
          w_reveal_nxt    = REVEAL_MAX;
          w_state_nxt     = SHOW;
          w_frame_cnt_nxt = '0;
        end else if (r_reveal_row >= REVEAL_MAX) begin
          w_state_nxt     = SHOW;
          w_frame_cnt_nxt = '0;
        end else if (bus.frame_start) begin
          w_reveal_nxt = (w_reveal_sum >= {1'b0, REVEAL_MAX}) ? REVEAL_MAX : w_reveal_sum[7:0];
        end
      end
      SHOW: begin
        if (w_btn_rise) begin
          w_state_nxt    = EXIT;
          w_exit_cnt_nxt = 1'b0;
        end else if (bus.frame_start) begin
          w_frame_cnt_nxt = r_frame_cnt + 6'd1;
        end
      end
      EXIT: begin
        if (bus.frame_start) begin
          if (r_exit_cnt) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_exit_cnt_nxt = 1'b1;
          end
        end
      end
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = FADE_IN;
    endcase
  end

  assign w_row      = bus.DrawY[9:1];
  assign w_col      = bus.DrawX[9:1];
  assign w_unused   = ^{bus.DrawX[0], bus.DrawY[0]};
  assign w_addr     = ROM_AW'(w_row) * ROM_AW'(IMG_W) + ROM_AW'(w_col);
  assign w_blink_on = ~r_frame_cnt[4];
  assign w_in_band  = (w_row >= 9'(BLINK_Y0)) && (w_row <= 9'(BLINK_Y1));

  always_comb begin
    w_flag = 1'b1;
    case (r_state)
      FADE_IN: w_flag = (w_row >= {1'b0, r_reveal_row});
      SHOW:    w_flag = w_in_band & ~w_blink_on;
      default: w_flag = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rom_addr    <= '0;
      r_de0         <= 1'b0;
      r_flag0       <= 1'b0;
      r_de_pipe     <= '0;
      r_flag_pipe   <= '0;
      r_index       <= '0;
      r_index_valid <= 1'b0;
    end else begin
      if (bus.de) r_rom_addr <= w_addr;
      r_de0          <= bus.de;
      r_flag0        <= w_flag;
      r_de_pipe[0]   <= r_de0;
      r_flag_pipe[0] <= r_flag0;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_de_pipe[i]   <= r_de_pipe[i-1];
        r_flag_pipe[i] <= r_flag_pipe[i-1];
      end
      r_index_valid <= r_de_pipe[ROM_LAT-1];
      r_index       <= (r_flag_pipe[ROM_LAT-1] | ~r_de_pipe[ROM_LAT-1]) ? 4'd0 : bus.rom_q;
    end
  end

  assign bus.rom_addr    = r_rom_addr;
  assign bus.index       = r_index;
  assign bus.index_valid = r_index_valid;
  assign bus.screen_done = r_screen_done;

endmodule

// File: tb/tb_start_screen_index_gen.sv
// Directed bench for start_screen_index_gen with a 1-cycle ROM model.
module tb_start_screen_index_gen;
  import start_screen_pkg::*;

  logic Clk;
  logic Reset;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  int   done_before;

  start_screen_index_gen_if bus ();

  start_screen_index_gen dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) bus.rom_q <= bus.rom_addr[3:0] ^ 4'h5;

  always @(posedge Clk) if (bus.screen_done === 1'b1) done_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [3:0] exp_q(input int x, input int y);
    int a;
    a = (y / 2) * 320 + (x / 2);
    return 4'(a) ^ 4'h5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic set_pix(input int x, input int y, input logic v);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    bus.de    = v;
  endtask

  task automatic pulse_frames(input int n);
    repeat (n) begin
      bus.frame_start = 1'b1;
      wait_cyc(1);
      bus.frame_start = 1'b0;
      wait_cyc(1);
    end
  endtask

  task automatic press_btn();
    bus.start_btn = 1'b1;
    wait_cyc(4);
    bus.start_btn = 1'b0;
    wait_cyc(3);
  endtask

  initial begin
    Reset = 1'b1;
    bus.start_btn   = 1'b0;
    bus.frame_start = 1'b0;
    set_pix(100, 50, 1'b1);
    wait_cyc(4);
    check("rst_index", 32'(bus.index), 32'd0);
    check("rst_valid", 32'(bus.index_valid), 32'd0);
    check("rst_addr", 32'(bus.rom_addr), 32'd0);
    check("rst_done", 32'(bus.screen_done), 32'd0);

    Reset = 1'b0;
    wait_cyc(2);
    check("lat_valid_early", 32'(bus.index_valid), 32'd0);
    wait_cyc(1);
    check("lat_valid", 32'(bus.index_valid), 32'd1);
    check("lat_addr", 32'(bus.rom_addr), 32'd8050);
    check("lat_index_masked", 32'(bus.index), 32'd0);

    // reveal_row = 40 after ten frames
    pulse_frames(10);
    set_pix(100, 78, 1'b1);
    wait_cyc(4);
    check("fade_row39", 32'(bus.index), 32'(exp_q(100, 78)));
    set_pix(100, 80, 1'b1);
    wait_cyc(4);
    check("fade_row40", 32'(bus.index), 32'd0);

    pulse_frames(49);
    check("fade_59_state", 32'(dut.r_state), 32'(FADE_IN));
    set_pix(100, 472, 1'b1);
    wait_cyc(4);
    check("fade_row236", 32'(bus.index), 32'd0);
    set_pix(100, 470, 1'b1);
    wait_cyc(4);
    check("fade_row235", 32'(bus.index), 32'(exp_q(100, 470)));
    pulse_frames(1);
    wait_cyc(1);
    check("fade_60_state", 32'(dut.r_state), 32'(SHOW));

    set_pix(200, 360, 1'b1);
    wait_cyc(4);
    check("blink_f0", 32'(bus.index), 32'(exp_q(200, 360)));
    pulse_frames(15);
    wait_cyc(4);
    check("blink_f15", 32'(bus.index), 32'(exp_q(200, 360)));
    pulse_frames(1);
    wait_cyc(4);
    check("blink_f16", 32'(bus.index), 32'd0);
    set_pix(200, 350, 1'b1);
    wait_cyc(4);
    check("blink_row175", 32'(bus.index), 32'(exp_q(200, 350)));
    set_pix(200, 352, 1'b1);
    wait_cyc(4);
    check("blink_row176", 32'(bus.index), 32'd0);
    set_pix(200, 398, 1'b1);
    wait_cyc(4);
    check("blink_row199", 32'(bus.index), 32'd0);
    set_pix(200, 400, 1'b1);
    wait_cyc(4);
    check("blink_row200", 32'(bus.index), 32'(exp_q(200, 400)));
    set_pix(200, 100, 1'b1);
    wait_cyc(4);
    check("blink_row50", 32'(bus.index), 32'(exp_q(200, 100)));
    set_pix(200, 360, 1'b1);
    pulse_frames(15);
    wait_cyc(4);
    check("blink_f31", 32'(bus.index), 32'd0);
    pulse_frames(1);
    wait_cyc(4);
    check("blink_f32", 32'(bus.index), 32'(exp_q(200, 360)));

    // back-to-back pixels, last three with de=0
    for (int k = 0; k < 11; k++) begin
      if (k >= 3) begin
        check("stream_valid", 32'(bus.index_valid), (k - 3 < 8) ? 32'd1 : 32'd0);
        check("stream_index", 32'(bus.index), (k - 3 < 8) ? 32'(exp_q(2 * (k - 3), 100)) : 32'd0);
      end
      set_pix(2 * k, 100, k < 8);
      wait_cyc(1);
    end

    Reset = 1'b1;
    wait_cyc(2);
    Reset = 1'b0;
    pulse_frames(2);
    set_pix(100, 400, 1'b1);
    wait_cyc(4);
    check("btn_pre_masked", 32'(bus.index), 32'd0);
    bus.start_btn = 1'b1;
    wait_cyc(4);
    check("btn_fade_state", 32'(dut.r_state), 32'(SHOW));
    wait_cyc(4);
    check("btn_full_image", 32'(bus.index), 32'(exp_q(100, 400)));
    wait_cyc(10);
    check("btn_held_state", 32'(dut.r_state), 32'(SHOW));
    bus.start_btn = 1'b0;
    wait_cyc(3);
    pulse_frames(5);
    check("coinc_cnt_pre", 32'(dut.r_frame_cnt), 32'd5);
    bus.start_btn = 1'b1;
    wait_cyc(2);
    bus.frame_start = 1'b1;
    wait_cyc(1);
    bus.frame_start = 1'b0;
    wait_cyc(1);
    check("coinc_state", 32'(dut.r_state), 32'(EXIT));
    check("coinc_cnt", 32'(dut.r_frame_cnt), 32'd5);
    bus.start_btn = 1'b0;
    set_pix(100, 100, 1'b1);
    wait_cyc(4);
    check("exit_index", 32'(bus.index), 32'd0);
    check("exit_valid", 32'(bus.index_valid), 32'd1);
    pulse_frames(1);
    wait_cyc(1);
    check("exit_f1_done", 32'(done_cnt), 32'd0);
    check("exit_f1_state", 32'(dut.r_state), 32'(EXIT));
    bus.frame_start = 1'b1;
    wait_cyc(1);
    bus.frame_start = 1'b0;
    check("exit_done_pulse", 32'(bus.screen_done), 32'd1);
    wait_cyc(1);
    check("exit_done_low", 32'(bus.screen_done), 32'd0);
    check("done_state", 32'(dut.r_state), 32'(DONE));
    pulse_frames(3);
    press_btn();
    check("done_stays", 32'(dut.r_state), 32'(DONE));
    check("done_once", 32'(done_cnt), 32'd1);
    check("done_index", 32'(bus.index), 32'd0);

    Reset = 1'b1;
    wait_cyc(2);
    Reset = 1'b0;
    wait_cyc(1);
    press_btn();
    press_btn();
    check("exit2_state", 32'(dut.r_state), 32'(EXIT));
    set_pix(300, 200, 1'b1);
    wait_cyc(4);
    check("exit2_valid", 32'(bus.index_valid), 32'd1);
    pulse_frames(1);
    done_before = done_cnt;
    #2;
    Reset = 1'b1;
    #1;
    check("async_valid", 32'(bus.index_valid), 32'd0);
    check("async_index", 32'(bus.index), 32'd0);
    check("async_addr", 32'(bus.rom_addr), 32'd0);
    check("async_state", 32'(dut.r_state), 32'(FADE_IN));
    bus.frame_start = 1'b1;
    wait_cyc(2);
    bus.frame_start = 1'b0;
    wait_cyc(2);
    check("async_no_done", 32'(done_cnt), 32'(done_before));
    Reset = 1'b0;
    wait_cyc(3);
    check("rerun_valid", 32'(bus.index_valid), 32'd1);
    check("rerun_addr", 32'(bus.rom_addr), 32'd32150);
    check("rerun_index", 32'(bus.index), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
